// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with start-glitch rejection and sticky framing error.
// Optional even parity (11-bit frames) when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       Rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       rx_busy,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
    } state_t;
`endif

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   take_bit;
    logic                   stop_ok;
    logic                   stop_bad;
`ifdef UART_RX_PARITY_EN
    logic                   take_par;
    logic                   par_q;
`endif

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign rx_busy = (state != IDLE);

    // Rx synchronizer; resets to the idle-high level
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
    end

    // State register plus baud counter, cleared on every transition
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state_n != state) ? '0 : cnt + CW'(1);
        end
    end

    // Next-state logic and sample strobes at bit centres
    always_comb begin
        state_n  = state;
        take_bit = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        take_par = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF) state_n = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (cnt == FULL) begin
                    take_bit = 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state_n = PARITY;
`else
                    if (bit_idx == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == FULL) begin
                    take_par = 1'b1;
                    state_n  = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == FULL) begin
                    stop_ok  = rx_s;
                    stop_bad = !rx_s;
                    state_n  = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Data path: shift in LSB first, index the bits
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else if (state_n == START && state == IDLE) begin
            bit_idx <= '0;
        end else if (take_bit) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Capture the received parity bit for the check at stop time
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)        par_q <= 1'b0;
        else if (take_par) par_q <= rx_s;
    end

    // Parity flag updates together with the byte delivery
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)       parity_err <= 1'b0;
        else if (stop_ok) parity_err <= ^{shreg, par_q};
    end
`endif

    // Output byte, one-cycle valid pulse and sticky framing error
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= stop_ok;
            if (stop_ok) begin
                rx_byte   <= shreg;
                frame_err <= 1'b0;
            end else if (stop_bad) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Expected bytes are queued when sent and checked on each byte_valid.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int SYN = 2;

    logic       CLK;
    logic       reset;
    logic       Rx;
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       rx_busy;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_pulse = 0;
    int busy_cnt = 0;
    logic prev_v = 1'b0;
    logic [8:0] sb[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (SYN)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .Rx        (Rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .rx_busy   (rx_busy),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err (frame_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d,
                              input logic stop_b,
                              input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ flip);
`endif
        send_bit(stop_b);
        Rx = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d, input logic flip);
        sb.push_back({flip, d});
        send_frame(d, 1'b1, flip);
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Output monitor: scoreboard pop on every delivered byte
    always @(negedge CLK) begin
        logic [8:0] e;
        if (rx_busy) busy_cnt++;
        if (reset && byte_valid) begin
            n_pulse++;
            chk("pulse_width", {31'd0, prev_v}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("rx_byte", {24'd0, rx_byte}, {24'd0, e[7:0]});
                chk("frame_err_ok", {31'd0, frame_err}, 32'd0);
`ifdef UART_RX_PARITY_EN
                chk("parity_err", {31'd0, parity_err}, {31'd0, e[8]});
`endif
            end
        end
        prev_v = byte_valid;
    end

    initial begin
        int p0;
        int b0;
        reset = 1'b0;
        Rx    = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_valid", {31'd0, byte_valid}, 32'd0);
        chk("rst_busy", {31'd0, rx_busy}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b1;
        idle(10);

        // single frame with busy-time measurement
        p0 = n_pulse;
        b0 = busy_cnt;
        send_good(8'hA5, 1'b0);
        idle(30);
        chk("t1_pulses", n_pulse - p0, 1);
`ifdef UART_RX_PARITY_EN
        chk("t1_busy", busy_cnt - b0, 32'(152 + CPB));
`else
        chk("t1_busy", busy_cnt - b0, 152);
`endif
        chk("t1_hold", {24'd0, rx_byte}, 32'hA5);
        chk("t1_ferr", {31'd0, frame_err}, 32'd0);

        // back-to-back frames, single stop bit
        p0 = n_pulse;
        send_good(8'h00, 1'b0);
        send_good(8'hFF, 1'b0);
        send_good(8'h3C, 1'b0);
        idle(40);
        chk("t2_pulses", n_pulse - p0, 3);
        chk("t2_drain", sb.size(), 0);

        // start-bit glitch
        p0 = n_pulse;
        Rx = 1'b0;
        repeat (5) @(negedge CLK);
        idle(40);
        chk("t3_pulses", n_pulse - p0, 0);
        chk("t3_busy", {31'd0, rx_busy}, 32'd0);
        chk("t3_ferr", {31'd0, frame_err}, 32'd0);

        // bad stop bit followed by a held-low line
        p0 = n_pulse;
        send_frame(8'h55, 1'b0, 1'b0);
        Rx = 1'b0;
        repeat (40) @(negedge CLK);
        chk("t4_break_busy", {31'd0, rx_busy}, 32'd1);
        idle(32);
        chk("t4_pulses", n_pulse - p0, 0);
        chk("t4_ferr", {31'd0, frame_err}, 32'd1);
        chk("t4_hold", {24'd0, rx_byte}, 32'h3C);
        chk("t4_idle", {31'd0, rx_busy}, 32'd0);
        send_good(8'h12, 1'b0);
        idle(30);
        chk("t4_recover", n_pulse - p0, 1);
        chk("t4_ferr_clr", {31'd0, frame_err}, 32'd0);

        // reset asserted in the middle of bit 4
        p0 = n_pulse;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1 & (8'h81 >> i));
        Rx = 1'b0;
        repeat (CPB / 2) @(negedge CLK);
        reset = 1'b0;
        #1;
        chk("t5_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("t5_valid", {31'd0, byte_valid}, 32'd0);
        chk("t5_busy", {31'd0, rx_busy}, 32'd0);
        chk("t5_ferr", {31'd0, frame_err}, 32'd0);
        Rx = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        idle(10);
        send_good(8'h7E, 1'b0);
        idle(30);
        chk("t5_pulses", n_pulse - p0, 1);
        chk("t5_after", {24'd0, rx_byte}, 32'h7E);

`ifdef UART_RX_PARITY_EN
        // even parity: correct then wrong
        p0 = n_pulse;
        send_good(8'h07, 1'b0);
        idle(20);
        send_good(8'h07, 1'b1);
        idle(20);
        chk("t6_pulses", n_pulse - p0, 2);
        chk("t6_perr", {31'd0, parity_err}, 32'd1);
`endif

        chk("final_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
